// File: rtl/arb_pkg.sv
// Shared types, sizes and one-hot/index helpers for the 4-way arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Expand an agent index into a one-hot vector.
  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  // Collapse a one-hot vector into an agent index (zero when the vector is empty).
  function automatic logic [ID_W-1:0] onehot_to_id(input logic [NUM_REQ-1:0] oh);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) id = ID_W'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/arb_rot_pri_enc4.sv
// Rotating priority encoder: the candidate at index ptr has top priority and
// priority descends modulo 4 from there. Built as rotate -> fixed encoder -> un-rotate.
module arb_rot_pri_enc4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] cand,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    win_id,
  output logic               win_vld
);

  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    rot_id;

  // Rotate so that cand[ptr] lands on bit 3, cand[ptr-1] on bit 2, and so on.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      logic [ID_W-1:0] src_idx;
      assign src_idx = ID_W'(gi) + ptr + ID_W'(1);
      assign rot[gi] = cand[src_idx];
    end
  endgenerate

  // Fixed-priority encode of the rotated vector, bit 3 highest.
  always_comb begin
    rot_id = '0;
    if (rot[3])      rot_id = 2'd3;
    else if (rot[2]) rot_id = 2'd2;
    else if (rot[1]) rot_id = 2'd1;
    else             rot_id = 2'd0;
  end

  // Undo the rotation to recover the real agent index.
  assign win_id  = rot_id + ptr + ID_W'(1);
  assign win_vld = |cand;

endmodule

// File: rtl/arb_rr_4.sv
// Four-requester arbiter with round-robin or fixed priority, grant hold until
// release, and an optional hold timeout that forces re-arbitration.
module arb_rr_4
  import arb_pkg::*;
#(
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_vld,
  output logic               timeout
);

  localparam int              HC_W       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST  = HC_W'(MAX_HOLD - 1);
  localparam bit              TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [ID_W-1:0] PTR_TOP    = ID_W'(NUM_REQ - 1);

  arb_state_e         state_reg, state_next;
  logic [ID_W-1:0]    ptr_reg, ptr_next;
  logic [HC_W-1:0]    hold_cnt_reg, hold_cnt_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [ID_W-1:0]    gnt_id_reg, gnt_id_next;
  logic               timeout_reg, timeout_next;

  logic [NUM_REQ-1:0] cand;
  logic [ID_W-1:0]    win_id;
  logic               win_vld;
  logic               owner_req;

  // While granted, the current owner is never a candidate: it only reaches the
  // encoder on release or timeout, and in both cases it must not win again.
  assign cand      = (state_reg == ARB_GRANT) ? (req & ~id_to_onehot(gnt_id_reg)) : req;
  assign owner_req = req[gnt_id_reg];

  arb_rot_pri_enc4 u_enc (
    .cand    (cand),
    .ptr     (ptr_reg),
    .win_id  (win_id),
    .win_vld (win_vld)
  );

  // Next-state logic: arbitration, release, hold counting and forced revocation.
  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    gnt_next      = gnt_reg;
    gnt_id_next   = gnt_id_reg;
    timeout_next  = 1'b0;

    unique case (state_reg)
      ARB_IDLE: begin
        if (win_vld) begin
          state_next    = ARB_GRANT;
          gnt_next      = id_to_onehot(win_id);
          gnt_id_next   = win_id;
          hold_cnt_next = '0;
          ptr_next      = (RR_MODE != 0) ? (win_id - ID_W'(1)) : PTR_TOP;
        end
      end

      ARB_GRANT: begin
        if (!owner_req) begin
          // Owner released: hand over immediately, or go idle if nobody waits.
          if (win_vld) begin
            gnt_next      = id_to_onehot(win_id);
            gnt_id_next   = win_id;
            hold_cnt_next = '0;
            ptr_next      = (RR_MODE != 0) ? (win_id - ID_W'(1)) : PTR_TOP;
          end else begin
            state_next    = ARB_IDLE;
            gnt_next      = '0;
            gnt_id_next   = '0;
            hold_cnt_next = '0;
          end
        end else if (TIMEOUT_EN && (hold_cnt_reg == HOLD_LAST)) begin
          // Hold limit reached: revoke only if someone else is waiting.
          if (win_vld) begin
            gnt_next      = id_to_onehot(win_id);
            gnt_id_next   = win_id;
            hold_cnt_next = '0;
            timeout_next  = 1'b1;
            ptr_next      = (RR_MODE != 0) ? (win_id - ID_W'(1)) : PTR_TOP;
          end else begin
            hold_cnt_next = '0;
          end
        end else begin
          hold_cnt_next = hold_cnt_reg + HC_W'(1);
        end
      end

      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any grant without a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ARB_IDLE;
      ptr_reg      <= PTR_TOP;
      hold_cnt_reg <= '0;
      gnt_reg      <= '0;
      gnt_id_reg   <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      gnt_reg      <= gnt_next;
      gnt_id_reg   <= gnt_id_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign gnt     = gnt_reg;
  assign gnt_id  = gnt_id_reg;
  assign gnt_vld = |gnt_reg;
  assign timeout = timeout_reg;

endmodule
